mux4_rr_sched: RTL and testbench
================================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler sharing one 4:1, 2-bit data selector between four requesters.
- Grants one channel at a time for a bounded slot.
- Drives the selector's sel code and the routed 2-bit data.
- Shows the granted channel number (0-3) on a common-cathode seven-segment digit.
- Sits between the four requesting sources and the shared selector/display path on the board.

Parameters:
HOLD_CYCLES, 4, clock cycles per grant slot; legal range 1..255.
CNT_W, 8, width of the slot down-counter; must hold HOLD_CYCLES-1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous reset, active-high.
req  input  4  request per channel; bit i = channel i. Level-sensitive; held while channel wants the resource.
A  input  2  data of channel 0.
B  input  2  data of channel 1.
C  input  2  data of channel 2.
D  input  2  data of channel 3.
grant  output  4  one-hot grant, registered; 0000 when idle.
sel  output  2  registered index of the granted channel; selector code.
busy  output  1  registered; 1 while any grant is held.
dataout  output  2  combinational: the selected input (A/B/C/D by sel) when busy=1, else 00.
seg7  output  7  registered segment pattern {g,f,e,d,c,b,a}, active-high.
ds  output  1  digit enable; constant 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; grant=0000; sel=00; busy=0; dataout=00.
  - seg7=7'b1000000 (dash); ds=0.
  - counter=0; last pointer=3, so channel 0 has first priority after reset.
- States: IDLE, GRANT.
- Round-robin pick: search order last+1, last+2, last+3, last (all mod 4). The first channel with req set wins.
- IDLE:
  - If req==0000, stay in IDLE; outputs hold reset values.
  - If any req bit is set, at the next edge: state=GRANT, sel=winner, grant=one-hot(winner), busy=1, counter=HOLD_CYCLES-1, seg7=digit(winner).
  - Latency from req rising to grant is 1 clock.
- GRANT, each edge:
  - Release occurs if counter==0, or if req[sel]==0 (early release).
  - No release: counter decrements; all outputs hold.
  - On release, last<=sel. If any req is set, the next winner is chosen with the updated last. The grant moves directly to it with no idle gap, counter reloads and seg7 updates.
  - On release with no req set: go to IDLE with reset output values (last is retained).
- Slot length: a continuously requesting channel holds the grant for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES=1 gives single-cycle slots.
- A sole requester that keeps req high is re-granted back-to-back. grant stays asserted continuously and seg7 does not change.
- Simultaneous events:
  - Release and new requests in the same cycle: new requests are evaluated in the same pick, with the released channel lowest priority.
  - A request arriving mid-slot waits. No preemption.
- Digit patterns:
  - 0: 0111111
  - 1: 0000110
  - 2: 1011011
  - 3: 1001111
  - idle: 1000000
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronously). last returns to 3.
- A..D changes during a grant propagate to dataout combinationally in the same cycle.

Test Plan:
- Reset: rst=1 at any point -> grant=0000, sel=00, busy=0, dataout=00, seg7=1000000, ds=0.
- Single request: req=0100, C=10, HOLD_CYCLES=4 -> one cycle later grant=0100, sel=10, seg7=1011011, dataout=10. Change C=01 mid-slot -> dataout=01 same cycle.
- Full contention: req=1111 held -> grants rotate 0,1,2,3,0, each lasting exactly 4 cycles with no gaps. seg7 steps 0111111, 0000110, 1011011, 1001111.
- Early release: req=0011, channel 0 granted; drop req[0] after 2 cycles -> grant moves to channel 1 on the next edge, slot of 4 cycles.
- Idle return: req=0001 for one cycle only -> granted for 1 cycle, then IDLE: grant=0000, seg7=1000000, dataout=00. Next req=1001 -> channel 3 wins, since last=0.
- Reset mid-operation: req=1111, assert rst during channel 2's slot -> outputs reset immediately. After rst deasserts, channel 0 is granted first. HOLD_CYCLES=1 run: req=1111 -> grant changes every cycle.

Source files
------------

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for four requesters sharing one 4:1 2-bit data selector.
// Grants one channel per bounded slot and shows the granted channel on a 7-segment digit.
module mux4_rr_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] C,
  input  logic [1:0] D,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic [1:0] dataout,
  output logic [6:0] seg7,
  output logic       ds
);

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_GRANT   = 1'b1;
  localparam logic [6:0]       SEG_IDLE   = 7'b1000000;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [6:0]       seg7_q, seg7_d;

  logic             rel_w;
  logic [1:0]       winner_w;
  logic             load_w;

  // Searches base+1, base+2, base+3, base: the lowest offset with a request wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [6:0] seg_of(input logic [1:0] ch);
    case (ch)
      2'd0:    seg_of = 7'b0111111;
      2'd1:    seg_of = 7'b0000110;
      2'd2:    seg_of = 7'b1011011;
      default: seg_of = 7'b1001111;
    endcase
  endfunction

  assign rel_w    = (state_q == ST_GRANT) && ((cnt_q == '0) || !req[sel_q]);
  // On release the channel just served becomes the pointer, so it ranks last in this same pick.
  assign winner_w = rr_pick(req, rel_w ? sel_q : last_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    seg7_d  = seg7_q;
    load_w  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) load_w = 1'b1;
      end
      default: begin
        if (rel_w) begin
          last_d = sel_q;
          if (|req) begin
            load_w = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sel_d   = 2'd0;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            seg7_d  = SEG_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    if (load_w) begin
      state_d = ST_GRANT;
      cnt_d   = CNT_RELOAD;
      sel_d   = winner_w;
      grant_d = 4'b0001 << winner_w;
      busy_d  = 1'b1;
      seg7_d  = seg_of(winner_w);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      seg7_q  <= SEG_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      seg7_q  <= seg7_d;
    end
  end

  always_comb begin
    dataout = 2'b00;
    if (busy_q) begin
      case (sel_q)
        2'd0:    dataout = A;
        2'd1:    dataout = B;
        2'd2:    dataout = C;
        default: dataout = D;
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign seg7  = seg7_q;
  assign ds    = 1'b0;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them. Two instances: 4-cycle slots and 1-cycle slots.
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic [1:0] A, B, C, D;
  logic [3:0] grant, grant1;
  logic [1:0] sel, sel1;
  logic       busy, busy1;
  logic [1:0] dataout, dataout1;
  logic [6:0] seg7, seg71;
  logic       ds, ds1;

  logic       nxt_rst;
  logic [1:0] nxt_a, nxt_b, nxt_c, nxt_d;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] dout;
    logic [6:0] seg;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mux4_rr_sched #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .A(A), .B(B), .C(C), .D(D),
    .grant(grant), .sel(sel), .busy(busy), .dataout(dataout), .seg7(seg7), .ds(ds)
  );

  mux4_rr_sched #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .A(A), .B(B), .C(C), .D(D),
    .grant(grant1), .sel(sel1), .busy(busy1), .dataout(dataout1), .seg7(seg71), .ds(ds1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got %b expected %b", name, cyc_cnt, act, exp_v);
    end
  endtask

  // Expected outputs for a cycle in which channel ch (or idle when ch < 0) is granted.
  function automatic exp_t mk(input int ch);
    exp_t e;
    logic [6:0] seg_tab [4];
    seg_tab[0] = 7'b0111111;
    seg_tab[1] = 7'b0000110;
    seg_tab[2] = 7'b1011011;
    seg_tab[3] = 7'b1001111;
    e.cyc = cyc_cnt;
    if (ch < 0) begin
      e.grant = 4'b0000; e.sel = 2'd0; e.busy = 1'b0; e.dout = 2'b00; e.seg = 7'b1000000;
    end else begin
      e.grant = 4'b0001 << ch;
      e.sel   = 2'(ch);
      e.busy  = 1'b1;
      e.seg   = seg_tab[ch];
      case (ch)
        0:       e.dout = A;
        1:       e.dout = B;
        2:       e.dout = C;
        default: e.dout = D;
      endcase
    end
    return e;
  endfunction

  // Drive this cycle's inputs just after the edge and record what the outputs must show this cycle.
  task automatic step(input int id, input logic [3:0] rv, input int ch);
    @(posedge clk);
    #1;
    rst = nxt_rst;
    A = nxt_a; B = nxt_b; C = nxt_c; D = nxt_d;
    if (id == 0) begin
      req = rv;
      q0.push_back(mk(ch));
    end else begin
      req1 = rv;
      q1.push_back(mk(ch));
    end
  endtask

  task automatic run(input int id, input logic [3:0] rv, input int ch, input int n);
    for (int i = 0; i < n; i++) step(id, rv, ch);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].cyc <= cyc_cnt) begin
      e = q0.pop_front();
      check("hold4_outputs", {grant, sel, busy, dataout, seg7}, {e.grant, e.sel, e.busy, e.dout, e.seg});
      check("hold4_ds", {15'd0, ds}, 16'd0);
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc_cnt) begin
      e = q1.pop_front();
      check("hold1_outputs", {grant1, sel1, busy1, dataout1, seg71}, {e.grant, e.sel, e.busy, e.dout, e.seg});
      check("hold1_ds", {15'd0, ds1}, 16'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; nxt_rst = 1'b1;
    req = 4'b0000; req1 = 4'b0000;
    nxt_a = 2'b01; nxt_b = 2'b10; nxt_c = 2'b10; nxt_d = 2'b11;
    A = nxt_a; B = nxt_b; C = nxt_c; D = nxt_d;

    // Reset values
    run(0, 4'b0000, -1, 2);
    nxt_rst = 1'b0;

    // Full contention after reset: 0,1,2,3,0 with 4-cycle slots and no gaps
    step(0, 4'b1111, -1);
    run(0, 4'b1111, 0, 4);
    run(0, 4'b1111, 1, 4);
    run(0, 4'b1111, 2, 4);
    run(0, 4'b1111, 3, 4);
    run(0, 4'b1111, 0, 3);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, -1);

    // Sole requester on channel 2: back-to-back slots, mid-slot data change seen same cycle
    step(0, 4'b0100, -1);
    step(0, 4'b0100, 2);
    nxt_c = 2'b01;
    run(0, 4'b0100, 2, 6);
    step(0, 4'b0000, 2);
    step(0, 4'b0000, -1);

    // One-cycle request on channel 0, early release to idle, then 1001 picks channel 3
    step(0, 4'b0001, -1);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, -1);
    step(0, 4'b1001, -1);
    run(0, 4'b1001, 3, 4);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, -1);

    // Reset asserted during channel 2's slot, then channel 0 first after release
    step(0, 4'b1111, -1);
    run(0, 4'b1111, 1, 4);
    run(0, 4'b1111, 2, 2);
    nxt_rst = 1'b1;
    run(0, 4'b1111, -1, 2);
    nxt_rst = 1'b0;
    step(0, 4'b1111, -1);

    // Early release: channel 0 drops after 2 granted cycles, channel 1 takes a full slot
    run(0, 4'b0011, 0, 2);
    step(0, 4'b0010, 0);
    run(0, 4'b0010, 1, 3);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, -1);

    // Single-cycle slots: grant moves every cycle under full contention
    step(1, 4'b1111, -1);
    step(1, 4'b1111, 0);
    step(1, 4'b1111, 1);
    step(1, 4'b1111, 2);
    step(1, 4'b1111, 3);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, -1);

    for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
    if ((q0.size() + q1.size()) > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q0.size() + q1.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
